vga_plot_arbiter: RTL and testbench

VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

---
 rtl/vga_arb_pkg.sv | 22 ++
 rtl/vga_rr_pick.sv | 25 ++
 rtl/vga_plot_arbiter.sv | 161 ++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_arb_pkg.sv
// Shared screen geometry, field widths and FSM encoding for the VGA plot arbiter.
package vga_arb_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int BURST_W  = 9;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_OWN   = 2'd2
  } arb_state_t;

  // A single requester still needs a 1-bit owner index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_rr_pick.sv
// Round-robin selector: first requester strictly after last_owner, wrapping around.
module vga_rr_pick
  import vga_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!valid && req[(int'(last_owner) + i) % NUM_REQ]) begin
        pick[(int'(last_owner) + i) % NUM_REQ] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Grants one drawing requester at a time access to the VGA adapter plot port.
// Define VGA_ARB_CLEAR_EN to sweep the whole screen to colour 0 after every reset.
module vga_plot_arbiter
  import vga_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 256
) (
  input  logic                      fastclock,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [X_W*NUM_REQ-1:0]    px_x,
  input  logic [Y_W*NUM_REQ-1:0]    px_y,
  input  logic [COLOUR_W*NUM_REQ-1:0] px_colour,
  input  logic [NUM_REQ-1:0]        px_valid,
  input  logic [NUM_REQ-1:0]        px_last,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [X_W-1:0]            x,
  output logic [Y_W-1:0]            y,
  output logic [COLOUR_W-1:0]       colour,
  output logic                      plot,
  output logic                      busy
);

  localparam int IDX_W = idx_width(NUM_REQ);

`ifdef VGA_ARB_CLEAR_EN
  localparam arb_state_t RESET_STATE = S_CLEAR;
`else
  localparam arb_state_t RESET_STATE = S_IDLE;
`endif

  arb_state_t            r_state, w_next;
  logic [IDX_W-1:0]      r_owner, r_last_owner, w_pick_idx;
  logic [NUM_REQ-1:0]    r_gnt, w_pick;
  logic                  w_pick_valid;
  logic [BURST_W-1:0]    r_count;
  logic [X_W-1:0]        r_x, w_own_x;
  logic [Y_W-1:0]        r_y, w_own_y;
  logic [COLOUR_W-1:0]   r_colour, w_own_colour;
  logic                  r_plot, r_busy;
  logic                  w_own_valid, w_own_last, w_own_req, w_burst_full, w_release;

  vga_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req),
    .last_owner (r_last_owner),
    .pick       (w_pick),
    .valid      (w_pick_valid)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) w_pick_idx = IDX_W'(i);
    end
  end

  // Only the current owner's lanes are ever looked at.
  always_comb begin
    w_own_x      = px_x[int'(r_owner)*X_W +: X_W];
    w_own_y      = px_y[int'(r_owner)*Y_W +: Y_W];
    w_own_colour = px_colour[int'(r_owner)*COLOUR_W +: COLOUR_W];
    w_own_valid  = px_valid[r_owner];
    w_own_last   = px_last[r_owner];
    w_own_req    = req[r_owner];
    w_burst_full = w_own_valid && (r_count == BURST_W'(MAX_BURST - 1));
    w_release    = (w_own_valid && w_own_last) || !w_own_req || w_burst_full;
  end

`ifdef VGA_ARB_CLEAR_EN
  logic [X_W-1:0] r_clr_x;
  logic [Y_W-1:0] r_clr_y;
  logic           w_clr_done;

  assign w_clr_done = (r_clr_x == X_W'(SCREEN_W - 1)) && (r_clr_y == Y_W'(SCREEN_H - 1));

  always_ff @(posedge fastclock) begin
    if (!resetn) begin
      r_clr_x <= '0;
      r_clr_y <= '0;
    end else if (r_state == S_CLEAR) begin
      if (r_clr_x == X_W'(SCREEN_W - 1)) begin
        r_clr_x <= '0;
        r_clr_y <= r_clr_y + 1'b1;
      end else begin
        r_clr_x <= r_clr_x + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
`ifdef VGA_ARB_CLEAR_EN
      S_CLEAR: if (w_clr_done) w_next = S_IDLE;
`endif
      S_IDLE:  if (w_pick_valid) w_next = S_OWN;
      S_OWN:   if (w_release) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Idle cycles register plot=0 even when the final pixel of a burst was just shown.
  always_ff @(posedge fastclock) begin
    if (!resetn) begin
      r_state      <= RESET_STATE;
      r_gnt        <= '0;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(NUM_REQ - 1);
      r_count      <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_colour     <= '0;
      r_plot       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_plot  <= 1'b0;
      r_busy  <= (w_next != S_IDLE) || (r_state == S_CLEAR);
      case (r_state)
`ifdef VGA_ARB_CLEAR_EN
        S_CLEAR: begin
          r_x      <= r_clr_x;
          r_y      <= r_clr_y;
          r_colour <= '0;
          r_plot   <= 1'b1;
        end
`endif
        S_IDLE: begin
          if (w_pick_valid) begin
            r_gnt        <= w_pick;
            r_owner      <= w_pick_idx;
            r_last_owner <= w_pick_idx;
            r_count      <= '0;
          end
        end
        S_OWN: begin
          r_x      <= w_own_x;
          r_y      <= w_own_y;
          r_colour <= w_own_colour;
          r_plot   <= w_own_valid;
          if (w_own_valid) r_count <= r_count + 1'b1;
          if (w_release) r_gnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign x      = r_x;
  assign y      = r_y;
  assign colour = r_colour;
  assign plot   = r_plot;
  assign busy   = r_busy;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: directed bursts plus random traffic
// against a cycle-level behavioural model of the arbitration rules.
module tb_vga_plot_arbiter;

  localparam int NUM_REQ   = 3;
  localparam int MAX_BURST = 256;
`ifdef VGA_ARB_CLEAR_EN
  localparam int CLEAR_CYCLES = 160 * 120;
`else
  localparam int CLEAR_CYCLES = 0;
`endif

  logic        fastclock = 1'b0;
  logic        resetn;
  logic [2:0]  req, px_valid, px_last, gnt;
  logic [23:0] px_x;
  logic [20:0] px_y;
  logic [8:0]  px_colour;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy;

  int checks = 0;
  int failures = 0;

  // Reference model state: owner -1 means nobody holds the bus.
  int          mOwner = -1, mLast = NUM_REQ - 1, mCount = 0, mClearIdx = CLEAR_CYCLES;
  logic [2:0]  mGnt = 0, mC = 0;
  logic [7:0]  mX = 0;
  logic [6:0]  mY = 0;
  logic        mPlot = 0, mBusy = 0;

  vga_plot_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
    .fastclock (fastclock),
    .resetn    (resetn),
    .req       (req),
    .px_x      (px_x),
    .px_y      (px_y),
    .px_colour (px_colour),
    .px_valid  (px_valid),
    .px_last   (px_last),
    .gnt       (gnt),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy)
  );

  always #5 fastclock = ~fastclock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic int ohIndex(input logic [2:0] g);
    for (int i = 0; i < 3; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Predict the outputs that follow the coming rising edge from the present inputs.
  task automatic modelStep();
    bit found;
    if (!resetn) begin
      mOwner = -1; mLast = NUM_REQ - 1; mCount = 0; mClearIdx = 0;
      mGnt = 0; mPlot = 0; mX = 0; mY = 0; mC = 0; mBusy = 0;
    end else if (mClearIdx < CLEAR_CYCLES) begin
      mX = 8'(mClearIdx % 160); mY = 7'(mClearIdx / 160); mC = 0;
      mPlot = 1; mGnt = 0; mBusy = 1;
      mClearIdx++;
    end else if (mOwner < 0) begin
      mPlot = 0; mGnt = 0; mBusy = 0;
      found = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!found && req[(mLast + k) % NUM_REQ]) begin
          found = 1;
          mOwner = (mLast + k) % NUM_REQ;
        end
      end
      if (found) begin
        mLast = mOwner; mCount = 0; mGnt = 3'(1 << mOwner); mBusy = 1;
      end
    end else begin
      mX = px_x[mOwner*8 +: 8]; mY = px_y[mOwner*7 +: 7]; mC = px_colour[mOwner*3 +: 3];
      mPlot = px_valid[mOwner];
      if (px_valid[mOwner]) mCount++;
      if ((px_valid[mOwner] && px_last[mOwner]) || !req[mOwner] || mCount == MAX_BURST) begin
        mOwner = -1; mGnt = 0; mBusy = 0;
      end
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge fastclock);
    #1;
    checkOutput("gnt", 32'(gnt), 32'(mGnt));
    checkOutput("plot", 32'(plot), 32'(mPlot));
    checkOutput("x", 32'(x), 32'(mX));
    checkOutput("y", 32'(y), 32'(mY));
    checkOutput("colour", 32'(colour), 32'(mC));
    checkOutput("busy", 32'(busy), 32'(mBusy));
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] v, input logic [2:0] l, input logic rn);
    resetn    = rn;
    req       = r;
    px_valid  = v;
    px_last   = l;
    px_x      = 24'($urandom);
    px_y      = 21'($urandom);
    px_colour = 9'($urandom);
  endtask

  initial begin
    int order[$];
    int gaps[$];
    int expOrder[4] = '{0, 1, 2, 0};
    int pix, gap, gntCycles, plots, gapB, phase;
    logic [2:0] v, l, prevG, firstG, rr, flip;

    // Reset and its output values.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(3'b000, 3'b000, 3'b000, 1'b0);
      tick();
    end
    checkOutput("reset_gnt", 32'(gnt), 0);
    checkOutput("reset_plot", 32'(plot), 0);
    checkOutput("reset_xy", 32'({x, y, colour}), 0);
    checkOutput("reset_busy", 32'(busy), 0);

`ifdef VGA_ARB_CLEAR_EN
    begin
      int clearPlots = 0;
      int gntSeen = 0;
      logic [7:0] lastX = 0;
      logic [6:0] lastY = 0;
      for (int c = 0; c < CLEAR_CYCLES; c++) begin
        applyStimulus(3'b111, 3'b000, 3'b000, 1'b1);
        tick();
        if (plot && colour == 0) clearPlots++;
        if (gnt != 0) gntSeen++;
        lastX = x; lastY = y;
      end
      checkOutput("clear_plots", 32'(clearPlots), 32'(CLEAR_CYCLES));
      checkOutput("clear_last_x", 32'(lastX), 159);
      checkOutput("clear_last_y", 32'(lastY), 119);
      checkOutput("clear_gnt_seen", 32'(gntSeen), 0);
    end
`endif

    // All three requesting, 4-pixel bursts: round-robin order with one-cycle gaps.
    pix = 0; gap = 0; prevG = 0;
    for (int c = 0; c < CLEAR_CYCLES + 200 && order.size() < 4; c++) begin
      v = 0; l = 0;
      if (mOwner >= 0) begin
        v[mOwner] = 1'b1;
        if (pix == 3) l[mOwner] = 1'b1;
        pix++;
      end else begin
        pix = 0;
      end
      applyStimulus(3'b111, v, l, 1'b1);
      tick();
      if (gnt != 0 && prevG == 0) begin
        order.push_back(ohIndex(gnt));
        if (order.size() > 1) gaps.push_back(gap);
      end
      if (gnt == 0) gap++; else gap = 0;
      prevG = gnt;
    end
    checkOutput("rr_grant_count", 32'(order.size()), 4);
    for (int i = 0; i < order.size(); i++) checkOutput($sformatf("rr_order%0d", i), 32'(order[i]), 32'(expOrder[i]));
    checkOutput("rr_gap_count", 32'(gaps.size()), 3);
    for (int i = 0; i < gaps.size(); i++) checkOutput($sformatf("rr_gap%0d", i), 32'(gaps[i]), 1);
    for (int c = 0; c < 2; c++) begin applyStimulus(3'b000, 3'b000, 3'b000, 1'b1); tick(); end

    // Owner 2 plots a known pixel while requester 0 chatters without effect.
    for (int c = 0; c < 8 && mOwner != 2; c++) begin
      applyStimulus(3'b101, 3'b000, 3'b000, 1'b1);
      tick();
    end
    checkOutput("own2_gnt", 32'(gnt), 32'(3'b100));
    applyStimulus(3'b101, 3'b101, 3'b000, 1'b1);
    px_x[16 +: 8] = 8'd10; px_y[14 +: 7] = 7'd5; px_colour[6 +: 3] = 3'b110;
    px_x[0 +: 8] = 8'd99;  px_y[0 +: 7] = 7'd44; px_colour[0 +: 3] = 3'b001;
    tick();
    checkOutput("own2_x", 32'(x), 10);
    checkOutput("own2_y", 32'(y), 5);
    checkOutput("own2_colour", 32'(colour), 6);
    checkOutput("own2_plot", 32'(plot), 1);
    applyStimulus(3'b101, 3'b001, 3'b000, 1'b1);
    tick();
    checkOutput("nonowner_plot", 32'(plot), 0);
    for (int c = 0; c < 2; c++) begin applyStimulus(3'b000, 3'b000, 3'b000, 1'b1); tick(); end

    // Requester 1 streams without px_last: forced release after MAX_BURST plots.
    gntCycles = 0; plots = 0; gapB = 0; phase = 0;
    for (int c = 0; c < 400 && phase < 3; c++) begin
      applyStimulus(3'b010, 3'b010, 3'b000, 1'b1);
      tick();
      if (phase == 0 && gnt[1]) phase = 1;
      else if (phase == 1 && gnt == 0) phase = 2;
      else if (phase == 2 && gnt[1]) phase = 3;
      if (phase == 1) gntCycles++;
      if (phase == 2) gapB++;
      if (phase == 1 || phase == 2) plots += int'(plot);
    end
    checkOutput("burst_regrant_seen", 32'(phase), 3);
    checkOutput("burst_plots", 32'(plots), 256);
    checkOutput("burst_gnt_cycles", 32'(gntCycles), 256);
    checkOutput("burst_gap", 32'(gapB), 1);
    for (int c = 0; c < 2; c++) begin applyStimulus(3'b000, 3'b000, 3'b000, 1'b1); tick(); end

    // Reset lands on pixel 7 of a burst; afterwards requester 0 must win first.
    pix = 0;
    for (int c = 0; c < 40 && pix < 7; c++) begin
      v = 0;
      if (mOwner >= 0) begin v[mOwner] = 1'b1; pix++; end
      applyStimulus(3'b110, v, 3'b000, (pix == 7) ? 1'b0 : 1'b1);
      tick();
    end
    checkOutput("midrst_pixel", 32'(pix), 7);
    checkOutput("midrst_gnt", 32'(gnt), 0);
    checkOutput("midrst_plot", 32'(plot), 0);
    firstG = 0;
    for (int c = 0; c < CLEAR_CYCLES + 20 && firstG == 0; c++) begin
      applyStimulus(3'b111, 3'b000, 3'b000, 1'b1);
      tick();
      firstG = gnt;
    end
    checkOutput("first_grant_after_reset", 32'(firstG), 32'(3'b001));

    // Random traffic against the model.
    rr = 3'b000;
    for (int c = 0; c < 1500; c++) begin
      flip = 0; l = 0;
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 5) == 0) flip[b] = 1'b1;
        if ($urandom_range(0, 7) == 0) l[b] = 1'b1;
      end
      rr = rr ^ flip;
      applyStimulus(rr, 3'($urandom), l, 1'b1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
